mc_control_fsm: RTL and testbench

//  Main control unit of the multicycle RV32 core; drives the ALU_RISCv sel/source muxes and consumes its flags.

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_control_fsm_alu_decoder.sv | 36 +++
 rtl/mc_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, opcodes, ALU and mux selects.
// MC_CTRL_BRANCH_EXT_EN widens the set of legal branch funct3 codes beyond beq.
package mc_ctrl_pkg;

  localparam int STATE_W   = 4;
  localparam int ALU_SEL_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BRANCH
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_SUB = 3'b001;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_AND = 3'b010;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_OR  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic branch_legal(input logic [2:0] f3);
`ifdef MC_CTRL_BRANCH_EXT_EN
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
`else
    return (f3 == 3'b000);
`endif
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// Combinational ALU-select decoder: maps alu_op / funct3 / funct7b5 / op[5] onto the ALU sel code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 bad_funct
);

  logic [ALU_SEL_W-1:0] f_sel;

  // bad_funct must not depend on alu_op: the FSM feeds alu_op from its next state.
  always_comb begin
    f_sel     = ALU_SEL_ADD;
    bad_funct = 1'b0;
    case (funct3)
      3'b000:  f_sel = (op5 && funct7b5) ? ALU_SEL_SUB : ALU_SEL_ADD;
      3'b010:  f_sel = ALU_SEL_SLT;
      3'b110:  f_sel = ALU_SEL_OR;
      3'b111:  f_sel = ALU_SEL_AND;
      default: bad_funct = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALUOP_ADD: alu_sel = ALU_SEL_ADD;
      ALUOP_SUB: alu_sel = ALU_SEL_SUB;
      default:   alu_sel = f_sel;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32 main control: Moore FSM with registered selects plus mem_ready/flag-gated strobes.
// MC_CTRL_BRANCH_EXT_EN adds bne/blt/bge branch conditions.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 negative,
  input  logic                 overflow,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 illegal_instr
);

  state_t               state, nxt;
  logic                 illegal_dec, take, bad_funct;
  logic [1:0]           dec_alu_op;
  logic [ALU_SEL_W-1:0] dec_sel;
  logic                 n_adr, n_mw, n_rw;
  logic [1:0]           n_rs, n_a, n_b;

  mc_alu_decoder u_alu_dec (
    .alu_op    (dec_alu_op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op5       (op[5]),
    .alu_sel   (dec_sel),
    .bad_funct (bad_funct)
  );

`ifdef MC_CTRL_BRANCH_EXT_EN
  always_comb begin
    case (funct3)
      3'b000:  take = zero;
      3'b001:  take = !zero;
      3'b100:  take = negative ^ overflow;
      3'b101:  take = !(negative ^ overflow);
      default: take = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign take         = zero;
  assign unused_flags = negative ^ overflow;
`endif

  always_comb begin
    nxt         = state;
    illegal_dec = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE: begin
            nxt         = bad_funct ? S_FETCH : S_EXECUTER;
            illegal_dec = bad_funct;
          end
          OP_ITYPE: begin
            nxt         = bad_funct ? S_FETCH : S_EXECUTEI;
            illegal_dec = bad_funct;
          end
          OP_BRANCH: begin
            nxt         = branch_legal(funct3) ? S_BRANCH : S_FETCH;
            illegal_dec = !branch_legal(funct3);
          end
          OP_JAL: nxt = S_JAL;
          default: begin
            nxt         = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR:   nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: nxt = (state == S_JAL || !illegal_dec) ? S_ALUWB : S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  // Register values are decoded from the next state so they line up with the state register.
  always_comb begin
    n_adr      = 1'b0;
    n_mw       = 1'b0;
    n_rw       = 1'b0;
    n_rs       = RES_ALUOUT;
    n_a        = SRCA_PC;
    n_b        = SRCB_RS2;
    dec_alu_op = ALUOP_ADD;
    case (nxt)
      S_FETCH: begin
        n_b  = SRCB_FOUR;
        n_rs = RES_ALU;
      end
      S_DECODE: begin
        n_a = SRCA_OLDPC;
        n_b = SRCB_IMM;
      end
      S_MEMADR: begin
        n_a = SRCA_RS1;
        n_b = SRCB_IMM;
      end
      S_MEMREAD: n_adr = 1'b1;
      S_MEMWB: begin
        n_rs = RES_DATA;
        n_rw = 1'b1;
      end
      S_MEMWRITE: begin
        n_adr = 1'b1;
        n_mw  = 1'b1;
      end
      S_EXECUTER: begin
        n_a        = SRCA_RS1;
        dec_alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        n_a        = SRCA_RS1;
        n_b        = SRCB_IMM;
        dec_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: n_rw = 1'b1;
      S_JAL: begin
        n_a = SRCA_OLDPC;
        n_b = SRCB_FOUR;
      end
      S_BRANCH: begin
        n_a        = SRCA_RS1;
        dec_alu_op = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      adr_src    <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      result_src <= RES_ALU;
      alu_src_a  <= SRCA_PC;
      alu_src_b  <= SRCB_FOUR;
      alu_sel    <= ALU_SEL_ADD;
    end else begin
      state      <= nxt;
      adr_src    <= n_adr;
      mem_write  <= n_mw;
      reg_write  <= n_rw;
      result_src <= n_rs;
      alu_src_a  <= n_a;
      alu_src_b  <= n_b;
      alu_sel    <= dec_sel;
    end
  end

  // Fetch strobes follow mem_ready live; rst_n masks them while reset is held in FETCH.
  assign ir_write      = rst_n && (state == S_FETCH) && mem_ready;
  assign pc_write      = rst_n && (((state == S_FETCH) && mem_ready) || (state == S_JAL) ||
                                   ((state == S_BRANCH) && take));
  assign illegal_instr = (state == S_DECODE) && illegal_dec;

  always_comb begin
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction table expanded into per-cycle expectations.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, negative, overflow, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_sel;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .negative(negative), .overflow(overflow), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_sel(alu_sel), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       pw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] sel;
    bit         chk_ab, chk_rs;
  } exp_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, n, v;
    int         fstall, mstall;
    logic [2:0] sel;
    logic       take, ill;
  } ins_t;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_JAL = 9, P_BRANCH = 10;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t ph(input int p, input logic [1:0] imm, input logic x,
                              input logic [2:0] sel);
    exp_t e;
    e = '{tag: "", pw: 1'b0, adr: 1'b0, mw: 1'b0, irw: 1'b0, rw: 1'b0, ill: 1'b0,
          rs: 2'b00, a: 2'b00, b: 2'b00, imm: imm, sel: 3'b000, chk_ab: 1'b0, chk_rs: 1'b0};
    case (p)
      P_FETCH:    begin e.tag = "FETCH"; e.pw = x; e.irw = x; e.b = 2'b10; e.rs = 2'b10;
                        e.chk_ab = 1'b1; e.chk_rs = 1'b1; end
      P_DECODE:   begin e.tag = "DECODE"; e.ill = x; e.a = 2'b01; e.b = 2'b01; e.chk_ab = 1'b1; end
      P_MEMADR:   begin e.tag = "MEMADR"; e.a = 2'b10; e.b = 2'b01; e.chk_ab = 1'b1; end
      P_MEMREAD:  begin e.tag = "MEMREAD"; e.adr = 1'b1; e.chk_rs = 1'b1; end
      P_MEMWB:    begin e.tag = "MEMWB"; e.rs = 2'b01; e.rw = 1'b1; e.chk_rs = 1'b1; end
      P_MEMWRITE: begin e.tag = "MEMWRITE"; e.adr = 1'b1; e.mw = 1'b1; end
      P_EXR:      begin e.tag = "EXECUTER"; e.a = 2'b10; e.sel = sel; e.chk_ab = 1'b1; end
      P_EXI:      begin e.tag = "EXECUTEI"; e.a = 2'b10; e.b = 2'b01; e.sel = sel; e.chk_ab = 1'b1; end
      P_ALUWB:    begin e.tag = "ALUWB"; e.rw = 1'b1; e.chk_rs = 1'b1; end
      P_JAL:      begin e.tag = "JAL"; e.a = 2'b01; e.b = 2'b10; e.pw = 1'b1;
                        e.chk_ab = 1'b1; e.chk_rs = 1'b1; end
      default:    begin e.tag = "BRANCH"; e.a = 2'b10; e.sel = 3'b001; e.pw = x;
                        e.chk_ab = 1'b1; e.chk_rs = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic step(input exp_t e, input logic mr);
    mem_ready = mr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (pc_write !== e.pw || adr_src !== e.adr || mem_write !== e.mw || ir_write !== e.irw ||
          reg_write !== e.rw || imm_src !== e.imm || illegal_instr !== e.ill ||
          (e.chk_ab && (alu_src_a !== e.a || alu_src_b !== e.b || alu_sel !== e.sel)) ||
          (e.chk_rs && result_src !== e.rs)) begin
        failures++;
        $display("FAIL %s @%0t: got pw=%b adr=%b mw=%b irw=%b rw=%b ill=%b imm=%b a=%b b=%b sel=%b rs=%b want pw=%b adr=%b mw=%b irw=%b rw=%b ill=%b imm=%b a=%b b=%b sel=%b rs=%b",
                 e.tag, $time, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
                 imm_src, alu_src_a, alu_src_b, alu_sel, result_src,
                 e.pw, e.adr, e.mw, e.irw, e.rw, e.ill, e.imm, e.a, e.b, e.sel, e.rs);
      end
    end
  end

  task automatic run_instr(input ins_t t);
    logic [1:0] imm;
    case (t.op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    op = t.op; funct3 = t.f3; funct7b5 = t.f7; zero = t.z; negative = t.n; overflow = t.v;
    for (int i = 0; i < t.fstall; i++) step(ph(P_FETCH, imm, 1'b0, 3'b000), 1'b0);
    step(ph(P_FETCH, imm, 1'b1, 3'b000), 1'b1);
    step(ph(P_DECODE, imm, t.ill, 3'b000), 1'b1);
    if (!t.ill) begin
      case (t.op)
        7'b0000011: begin
          step(ph(P_MEMADR, imm, 1'b0, 3'b000), 1'b1);
          for (int i = 0; i < t.mstall; i++) step(ph(P_MEMREAD, imm, 1'b0, 3'b000), 1'b0);
          step(ph(P_MEMREAD, imm, 1'b0, 3'b000), 1'b1);
          step(ph(P_MEMWB, imm, 1'b0, 3'b000), 1'b1);
        end
        7'b0100011: begin
          step(ph(P_MEMADR, imm, 1'b0, 3'b000), 1'b1);
          for (int i = 0; i < t.mstall; i++) step(ph(P_MEMWRITE, imm, 1'b0, 3'b000), 1'b0);
          step(ph(P_MEMWRITE, imm, 1'b0, 3'b000), 1'b1);
        end
        7'b0110011: begin
          step(ph(P_EXR, imm, 1'b0, t.sel), 1'b1);
          step(ph(P_ALUWB, imm, 1'b0, 3'b000), 1'b1);
        end
        7'b0010011: begin
          step(ph(P_EXI, imm, 1'b0, t.sel), 1'b1);
          step(ph(P_ALUWB, imm, 1'b0, 3'b000), 1'b1);
        end
        7'b1101111: begin
          step(ph(P_JAL, imm, 1'b0, 3'b000), 1'b1);
          step(ph(P_ALUWB, imm, 1'b0, 3'b000), 1'b1);
        end
        default: step(ph(P_BRANCH, imm, t.take, 3'b000), 1'b1);
      endcase
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    ins_t tbl[$];
    ins_t t;
    logic bx_ill;
`ifdef MC_CTRL_BRANCH_EXT_EN
    bx_ill = 1'b0;
`else
    bx_ill = 1'b1;
`endif
    //            name     op           f3      f7    z     n     v   fst mst  sel     take  ill
    tbl.push_back('{"add",  7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b001, 1'b0, 1'b0});
    tbl.push_back('{"slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b101, 1'b0, 1'b0});
    tbl.push_back('{"or",   7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b011, 1'b0, 1'b0});
    tbl.push_back('{"and",  7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b010, 1'b0, 1'b0});
    tbl.push_back('{"addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"ori",  7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b011, 1'b0, 1'b0});
    tbl.push_back('{"sll",  7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{"lw3",  7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"lw0",  7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"sw2",  7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"beqT", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000, 1'b1, 1'b0});
    tbl.push_back('{"beqN", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"bne",  7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b1, bx_ill});
    tbl.push_back('{"blt",  7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b000, 1'b1, bx_ill});
    tbl.push_back('{"bge",  7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b000, 1'b0, bx_ill});
    tbl.push_back('{"bxx",  7'b1100011, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{"jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0});
    tbl.push_back('{"bad",  7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b1});
    tbl.push_back('{"add2", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3'b000, 1'b0, 1'b0});

    rst_n = 1'b0; mem_ready = 1'b1;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; negative = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst_pc_write",  {2'b00, pc_write},  3'b000);
    check1("rst_ir_write",  {2'b00, ir_write},  3'b000);
    check1("rst_mem_write", {2'b00, mem_write}, 3'b000);
    check1("rst_reg_write", {2'b00, reg_write}, 3'b000);
    check1("rst_illegal",   {2'b00, illegal_instr}, 3'b000);
    check1("rst_src_a",     {1'b0, alu_src_a},  3'b000);
    check1("rst_src_b",     {1'b0, alu_src_b},  3'b010);
    check1("rst_result",    {1'b0, result_src}, 3'b010);
    check1("rst_alu_sel",   alu_sel,            3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i]);

    // sw stalled in MEMWRITE, then reset asserted between clock edges
    t = tbl[10];
    op = t.op; funct3 = t.f3; funct7b5 = 1'b0;
    step(ph(P_FETCH, 2'b01, 1'b1, 3'b000), 1'b1);
    step(ph(P_DECODE, 2'b01, 1'b0, 3'b000), 1'b1);
    step(ph(P_MEMADR, 2'b01, 1'b0, 3'b000), 1'b1);
    step(ph(P_MEMWRITE, 2'b01, 1'b0, 3'b000), 1'b0);
    #2;
    check1("mw_before_rst", {2'b00, mem_write}, 3'b001);
    rst_n = 1'b0;
    #1;
    check1("mw_async_drop", {2'b00, mem_write}, 3'b000);
    check1("adr_async_drop", {2'b00, adr_src},  3'b000);
    check1("rw_during_rst", {2'b00, reg_write}, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(tbl[0]);

    @(negedge clk); #1;
    check1("queue_drained", (q.size() == 0) ? 3'b001 : 3'b000, 3'b001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
